// File: rtl/reg_scoreboard_pkg.sv
// Shared register-naming types and scoreboard defaults for the decode stage.
package reg_scoreboard_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_W     = $clog2(REG_COUNT);

    typedef logic [REG_W-1:0] regName_t;

    localparam int unsigned SB_MAX_OUTSTANDING = 4;

    // One-hot mask selecting a single architectural register.
    function automatic logic [REG_COUNT-1:0] reg_onehot(input regName_t r);
        return REG_COUNT'(1) << r;
    endfunction

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational hazard evaluation: pending bits with same-cycle writeback bypass,
// RAW/WAW detection and the capacity check.
module sb_hazard_check
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = SB_MAX_OUTSTANDING,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic [REG_COUNT-1:0] pending,
    input  logic [CNT_W-1:0]     outstanding,
    input  logic                 wb_valid,
    input  regName_t             wb_rd,
    input  logic                 flush,
    input  logic                 issue_wen,
    input  regName_t             issue_rd,
    input  regName_t             rs1,
    input  regName_t             rs2,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    output logic                 raw_c,
    output logic                 waw_c,
    output logic                 full_c,
    output logic                 release_c
);

    logic [REG_COUNT-1:0] wb_mask;
    logic [REG_COUNT-1:0] eff;

    // Writeback releases its register in the same cycle (regfile writes on negedge).
    always_comb begin
        wb_mask = '0;
        if (wb_valid && !flush) begin
            wb_mask = reg_onehot(wb_rd);
        end
        eff = pending & ~wb_mask;
    end

    assign raw_c = (use_rs1 & eff[rs1]) | (use_rs2 & eff[rs2]);
    assign waw_c = issue_wen & eff[issue_rd];

    // Only a writeback that actually frees an entry makes room, so a stray
    // writeback can never let the counter run past its limit.
    assign release_c = wb_valid & ~flush & (wb_rd != '0) & pending[wb_rd];
    assign full_c    = (outstanding == CNT_W'(MAX_OUTSTANDING)) & ~release_c;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight destination registers
// until writeback and stalls decode on RAW/WAW hazards or a full tracker.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = SB_MAX_OUTSTANDING,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  regName_t         issue_rd,
    input  logic             issue_wen,
    input  regName_t         rs1,
    input  regName_t         rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             wb_valid,
    input  regName_t         wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic             issue_ack,
    output logic [CNT_W-1:0] outstanding,
    output logic             busy,
    output logic             err
);

    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 raw_c;
    logic                 waw_c;
    logic                 full_c;
    logic                 release_c;
    logic                 set_c;
    logic                 wb_bad_c;

    sb_hazard_check #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_hazard (
        .pending     (pending),
        .outstanding (outstanding),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .raw_c       (raw_c),
        .waw_c       (waw_c),
        .full_c      (full_c),
        .release_c   (release_c)
    );

    // Zero-latency handshake; both held low while reset is asserted.
    assign stall = ~rst & issue_valid & ~flush
                 & (raw_c | waw_c | (issue_wen & (issue_rd != '0) & full_c));
    assign issue_ack = ~rst & issue_valid & ~flush & ~stall;
    assign busy      = (outstanding != '0);

    assign set_c    = issue_ack & issue_wen & (issue_rd != '0);
    assign wb_bad_c = wb_valid & (wb_rd != '0) & ~pending[wb_rd];

    // Clear on writeback first, then set on issue so a same-register pair keeps the bit.
    always_comb begin
        pending_nxt = pending;
        cnt_nxt     = outstanding;
        if (release_c) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (set_c) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
        unique case ({set_c, release_c})
            2'b10:   cnt_nxt = outstanding + CNT_W'(1);
            2'b01:   cnt_nxt = outstanding - CNT_W'(1);
            default: cnt_nxt = outstanding;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else if (flush) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            pending     <= pending_nxt;
            outstanding <= cnt_nxt;
            if (wb_bad_c) begin
                err <= 1'b1;
            end
        end
    end

endmodule
